// File: rtl/ring_step_ctrl_pkg.sv
// Shared types and constants for the ring step controller.
// State encoding, direction constants and ring helpers.
package ring_step_ctrl_pkg;

  localparam int RING_SIZE = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAN  = 2'd1,
    ST_MOVE  = 2'd2,
    ST_DWELL = 2'd3
  } state_t;

  function automatic logic [2:0] gray3(
    input logic [2:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] ring_delta(
    input logic [2:0] to,
    input logic [2:0] from
  );
    return 3'(to - from);
  endfunction

endpackage

// File: rtl/ring_counter3.sv
// 3-bit up/down position counter for the ring step controller.
// Wraps naturally modulo 8 in both directions.
module ring_counter3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_up,
  output logic [2:0] o_cnt
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= i_up ? r_cnt + 3'd1 : r_cnt - 3'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ring_step_ctrl.sv
// Ring step controller: shortest-path stepping on an 8-position ring.
// Optional abort feature enabled by macro RING_STEP_ABORT_EN.
module ring_step_ctrl
  import ring_step_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_target,
  input  logic       step_ok,
  output logic [2:0] pos,
  output logic [2:0] pos_gray,
  output logic       dir,
`ifdef RING_STEP_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       moving,
  output logic       done
);

  localparam logic [3:0] DW_LAST =
    (DWELL_CYCLES < 1) ? 4'd0 : 4'(DWELL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_target;
  logic       r_dir;
  logic       w_dir_nxt;
  logic [3:0] r_dwell;
  logic [3:0] w_dwell_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_step;
  logic [2:0] w_pos;
  logic [2:0] w_delta;
  logic [2:0] w_step_pos;
`ifdef RING_STEP_ABORT_EN
  logic       r_aborted;
  logic       w_abrt_nxt;
`endif

  ring_counter3 u_pos (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_step),
    .i_up  (r_dir),
    .o_cnt (w_pos)
  );

  assign w_delta    = ring_delta(r_target, w_pos);
  assign w_step_pos = r_dir ? w_pos + 3'd1 : w_pos - 3'd1;

  always_comb begin
    w_next      = r_state;
    w_dir_nxt   = r_dir;
    w_dwell_nxt = r_dwell;
    w_done_nxt  = 1'b0;
    w_step      = 1'b0;
`ifdef RING_STEP_ABORT_EN
    w_abrt_nxt  = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_PLAN;
      end
      ST_PLAN: begin
`ifdef RING_STEP_ABORT_EN
        if (abort) begin
          w_next     = ST_DWELL;
          w_abrt_nxt = 1'b1;
        end else
`endif
        if (w_delta == 3'd0) begin
          w_next     = ST_DWELL;
          w_done_nxt = 1'b1;
        end else begin
          // Half-way tie (delta 4) resolves upward
          w_dir_nxt = (w_delta <= 3'd4) ? DIR_UP : DIR_DOWN;
          w_next    = ST_MOVE;
        end
      end
      ST_MOVE: begin
`ifdef RING_STEP_ABORT_EN
        if (abort) begin
          w_next     = ST_DWELL;
          w_abrt_nxt = 1'b1;
        end else
`endif
        if (step_ok) begin
          w_step = 1'b1;
          if (w_step_pos == r_target) begin
            w_next     = ST_DWELL;
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        if (r_dwell == DW_LAST) begin
          w_next      = ST_IDLE;
          w_dwell_nxt = '0;
        end else begin
          w_dwell_nxt = r_dwell + 4'd1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_dir    <= DIR_UP;
      r_dwell  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dir   <= w_dir_nxt;
      r_dwell <= w_dwell_nxt;
      r_done  <= w_done_nxt;
      if (r_state == ST_IDLE && req_valid) begin
        r_target <= req_target;
      end
    end
  end

`ifdef RING_STEP_ABORT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_aborted <= 1'b0;
    else        r_aborted <= w_abrt_nxt;
  end

  assign aborted = r_aborted;
`endif

  assign req_ready = (r_state == ST_IDLE);
  assign moving    = (r_state == ST_MOVE);
  assign done      = r_done;
  assign dir       = r_dir;
  assign pos       = w_pos;
  assign pos_gray  = gray3(w_pos);

endmodule
